// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:2 stream demultiplexer.
//   SEL_Y0 / SEL_Y1 : values of the route select that pick output 0 / output 1
//   next_count      : wrap-around increment used by the per-output transfer counters
package demux_pkg;

    localparam logic SEL_Y0 = 1'b0;
    localparam logic SEL_Y1 = 1'b1;

    // Widest counter supported by next_count; callers narrow the result to their own width,
    // which gives the wrap from 2^CNT_W-1 to 0 for free.
    localparam int unsigned MAX_CNT_W = 32;

    function automatic logic [MAX_CNT_W-1:0] next_count(input logic [MAX_CNT_W-1:0] count);
        return count + {{(MAX_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output side of the demultiplexer: a single-entry valid/data register with a
// ready/valid consumer interface and a count of completed transfers.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : write load_data into the slot this cycle
//   load_data   : data to store
//   out_ready   : consumer takes the slot contents this cycle
//   valid, data : slot contents presented to the consumer
//   count       : completed consumer handshakes (wraps)
//   can_accept  : slot can take a load this cycle (empty, or draining now)
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        drain   = valid_q && out_ready;

        if (drain) begin
            valid_d = 1'b0;
            count_d = CNT_W'(next_count(MAX_CNT_W'(count_q)));
        end
        // A load in the same cycle as a drain overrides the clear: no bubble.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign count      = count_q;
    assign can_accept = !valid_q || out_ready;

endmodule

// File: rtl/demux_1x2_reg.sv
// Registered 1:2 stream demultiplexer. One valid/ready producer is routed by s to one of
// two single-entry output slots, each with its own consumer handshake and transfer counter.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid, in_ready, d  : producer stream
//   s                      : route select (0 -> y0, 1 -> y1), held with d until accepted
//   y0_valid, y0_ready, y0 : consumer 0 stream
//   y1_valid, y1_ready, y1 : consumer 1 stream
//   y0_count, y1_count     : completed handshakes per output (wrap)
// in_ready follows only the selected slot, so a stalled slot blocks the input even when
// the other slot is free (intended head-of-line behaviour).
module demux_1x2_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [WIDTH-1:0] y1,
    output logic [CNT_W-1:0] y0_count,
    output logic [CNT_W-1:0] y1_count
);

    logic can_accept0, can_accept1;
    logic accept, load0, load1;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (s == SEL_Y1) ? can_accept1 : can_accept0;
        end
        accept = in_valid && in_ready;
        load0  = accept && (s == SEL_Y0);
        load1  = accept && (s == SEL_Y1);
    end

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load0),
        .load_data  (d),
        .out_ready  (y0_ready),
        .valid      (y0_valid),
        .data       (y0),
        .count      (y0_count),
        .can_accept (can_accept0)
    );

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .load_data  (d),
        .out_ready  (y1_ready),
        .valid      (y1_valid),
        .data       (y1),
        .count      (y1_count),
        .can_accept (can_accept1)
    );

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Bench for demux_1x2_reg. A driver issues directed transfers and pushes each accepted
// datum into a per-output queue; a monitor on the falling edge tracks expected slot
// occupancy and counts, and pops/compares whenever an output handshake happens.
// A second instance with 2-bit counters shares all inputs to exercise counter wrap.
module tb_demux_1x2_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       s;
    logic       y0_valid, y1_valid;
    logic       y0_ready, y1_ready;
    logic [7:0] y0, y1;
    logic [7:0] y0_count, y1_count;

    logic       c2_in_ready, c2_y0_valid, c2_y1_valid;
    logic [7:0] c2_y0, c2_y1;
    logic [1:0] c2_y0_count, c2_y1_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    demux_1x2_reg #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .s        (s),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y0       (y0),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .y1       (y1),
        .y0_count (y0_count),
        .y1_count (y1_count)
    );

    demux_1x2_reg #(.WIDTH(8), .CNT_W(2)) dut_w2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (c2_in_ready),
        .d        (d),
        .s        (s),
        .y0_valid (c2_y0_valid),
        .y0_ready (y0_ready),
        .y0       (c2_y0),
        .y1_valid (c2_y1_valid),
        .y1_ready (y1_ready),
        .y1       (c2_y1),
        .y0_count (c2_y0_count),
        .y1_count (c2_y1_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- monitor / reference model ----------------
    logic       m_v0 = 1'b0, m_v1 = 1'b0;
    int         m_c0 = 0, m_c1 = 0;
    logic       p_hold0 = 1'b0, p_hold1 = 1'b0;
    logic [7:0] p_y0, p_y1;
    logic       p_pend = 1'b0;
    logic       p_s;
    logic [7:0] p_d;

    always @(negedge clk) begin
        logic       exp_rdy;
        logic       ld0, ld1, dr0, dr1;
        logic [7:0] e;
        if (mon_en) begin
            exp_rdy = !rst && (s ? (!m_v1 || y1_ready) : (!m_v0 || y0_ready));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("y0_valid", 32'(y0_valid), 32'(m_v0));
            chk("y1_valid", 32'(y1_valid), 32'(m_v1));
            chk("y0_count", 32'(y0_count), 32'(m_c0 % 256));
            chk("y1_count", 32'(y1_count), 32'(m_c1 % 256));
            chk("y0_count_w2", 32'(c2_y0_count), 32'(m_c0 % 4));
            chk("y1_count_w2", 32'(c2_y1_count), 32'(m_c1 % 4));
            if (p_hold0) chk("y0_hold", 32'(y0), 32'(p_y0));
            if (p_hold1) chk("y1_hold", 32'(y1), 32'(p_y1));
            if (p_pend && in_valid) begin
                chk("producer_stable_s", 32'(s), 32'(p_s));
                chk("producer_stable_d", 32'(d), 32'(p_d));
            end
            p_hold0 = !rst && y0_valid && !y0_ready;
            p_hold1 = !rst && y1_valid && !y1_ready;
            p_y0    = y0;
            p_y1    = y1;
            p_pend  = in_valid && !exp_rdy && !rst;
            p_s     = s;
            p_d     = d;

            if (rst) begin
                m_v0 = 1'b0;
                m_v1 = 1'b0;
                m_c0 = 0;
                m_c1 = 0;
                q0.delete();
                q1.delete();
            end else begin
                dr0 = m_v0 && y0_ready;
                dr1 = m_v1 && y1_ready;
                ld0 = in_valid && exp_rdy && !s;
                ld1 = in_valid && exp_rdy && s;
                if (dr0) begin
                    if (q0.size() == 0) begin
                        chk("y0_unexpected_drain", 32'(y0), 32'hFFFF_FFFF);
                    end else begin
                        e = q0.pop_front();
                        chk("y0_data", 32'(y0), 32'(e));
                    end
                    m_c0++;
                end
                if (dr1) begin
                    if (q1.size() == 0) begin
                        chk("y1_unexpected_drain", 32'(y1), 32'hFFFF_FFFF);
                    end else begin
                        e = q1.pop_front();
                        chk("y1_data", 32'(y1), 32'(e));
                    end
                    m_c1++;
                end
                m_v0 = ld0 ? 1'b1 : (dr0 ? 1'b0 : m_v0);
                m_v1 = ld1 ? 1'b1 : (dr1 ? 1'b0 : m_v1);
            end
        end
    end

    // ---------------- driver ----------------
    // Presents (sel, data) until accepted; returns #1 after the accepting edge.
    task automatic send(input logic sel, input logic [7:0] data, output int tries);
        logic acc;
        acc      = 1'b0;
        tries    = 0;
        in_valid = 1'b1;
        s        = sel;
        d        = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sel) q1.push_back(data);
                else     q0.push_back(data);
                acc   = 1'b1;
                tries = i;
                break;
            end
        end
        if (!acc) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int wexp[5];
        wexp = '{1, 2, 3, 0, 1};

        // 1. reset with in_valid asserted
        rst      = 1'b1;
        in_valid = 1'b1;
        s        = 1'b0;
        d        = 8'hEE;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_y0_valid", 32'(y0_valid), 32'(0));
        chk("rst_y1_valid", 32'(y1_valid), 32'(0));
        chk("rst_y0", 32'(y0), 32'(0));
        chk("rst_y1", 32'(y1), 32'(0));
        chk("rst_y0_count", 32'(y0_count), 32'(0));
        chk("rst_y1_count", 32'(y1_count), 32'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;

        // 2. basic route to y0, then drain
        send(1'b0, 8'hA5, t);
        @(negedge clk);
        chk("route_y0_valid", 32'(y0_valid), 32'(1));
        chk("route_y0", 32'(y0), 32'hA5);
        chk("route_y1_valid", 32'(y1_valid), 32'(0));
        @(posedge clk);
        #1;
        y0_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("route_y0_count", 32'(y0_count), 32'(1));
        chk("route_y0_empty", 32'(y0_valid), 32'(0));
        y0_ready = 1'b0;

        // 3. back-to-back on y1, no bubble
        y1_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, 8'(i), t);
            chk("b2b_first_try", 32'(t), 32'(0));
        end
        @(posedge clk);
        #1;
        chk("b2b_y1_count", 32'(y1_count), 32'(3));
        y1_ready = 1'b0;

        // 4. backpressure / head-of-line blocking
        send(1'b0, 8'h10, t);
        in_valid = 1'b1;
        s        = 1'b0;
        d        = 8'h11;
        repeat (3) begin
            @(negedge clk);
            chk("hol_in_ready", 32'(in_ready), 32'(0));
            chk("hol_y0_held", 32'(y0), 32'h10);
            chk("hol_y1_empty", 32'(y1_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        y0_ready = 1'b1;
        @(negedge clk);
        chk("hol_release_ready", 32'(in_ready), 32'(1));
        q0.push_back(8'h11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        y0_ready = 1'b0;

        // 5. counter wrap on the 2-bit instance
        pulse_reset();
        y0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 8'(8'h20 + i), t);
            @(posedge clk);
            #1;
            chk("wrap_y0_count_w2", 32'(c2_y0_count), 32'(wexp[i]));
        end
        y0_ready = 1'b0;

        // 6. reset with both slots full
        send(1'b0, 8'h55, t);
        send(1'b1, 8'h66, t);
        @(negedge clk);
        chk("full_y0_valid", 32'(y0_valid), 32'(1));
        chk("full_y1_valid", 32'(y1_valid), 32'(1));
        @(posedge clk);
        #1;
        pulse_reset();
        chk("mid_rst_y0_valid", 32'(y0_valid), 32'(0));
        chk("mid_rst_y1_valid", 32'(y1_valid), 32'(0));
        chk("mid_rst_y0_count", 32'(y0_count), 32'(0));
        chk("mid_rst_y1_count", 32'(y1_count), 32'(0));
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_y0_count", 32'(y0_count), 32'(0));
        chk("post_rst_y1_count", 32'(y1_count), 32'(0));
        chk("q0_empty", 32'(q0.size()), 32'(0));
        chk("q1_empty", 32'(q1.size()), 32'(0));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
